// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised Moore sequence detector.
// Next-state values are folded to constants at elaboration time.
package seq_det_pkg;

  localparam int MAX_SEQ_LEN = 16;

  // Longest proper suffix of prefix_k that is also a pattern prefix.
  function automatic int seq_fail(
    input logic [MAX_SEQ_LEN-1:0] seq,
    input int                     len,
    input int                     k
  );
    int  best;
    bit  ok;
    best = 0;
    for (int m = 1; m < MAX_SEQ_LEN; m++) begin
      if (m < k) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_SEQ_LEN; t++) begin
          if (t < m) begin
            if (seq[len-1-(k-m+t)] != seq[len-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

  function automatic int seq_step(
    input logic [MAX_SEQ_LEN-1:0] seq,
    input int                     len,
    input int                     j,
    input logic                   b
  );
    int   best;
    int   i;
    bit   ok;
    logic sb;
    best = 0;
    if (j < len && b == seq[len-1-j]) return j + 1;
    for (int m = 1; m <= MAX_SEQ_LEN; m++) begin
      if (m <= j) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_SEQ_LEN; t++) begin
          if (t < m) begin
            i  = j + 1 - m + t;
            sb = (i < j) ? seq[len-1-i] : b;
            if (sb != seq[len-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

  function automatic int seq_next(
    input logic [MAX_SEQ_LEN-1:0] seq,
    input int                     len,
    input int                     k,
    input logic                   din_b,
    input bit                     overlap
  );
    int j;
    if (k == len) j = overlap ? seq_fail(seq, len, len) : 0;
    else if (k > len) j = 0;
    else j = k;
    return seq_step(seq, len, j, din_b);
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state lookup for the sequence detector.
// One constant per (state, bit) pair, selected by the live state.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] SEQ     = 3'b101,
  parameter int                 OVERLAP = 1,
  localparam int                SW      = $clog2(SEQ_LEN + 1)
) (
  input  logic [SW-1:0] ps,
  input  logic          din,
  output logic [SW-1:0] ps_nxt
);

  localparam int NS = 1 << SW;
  localparam logic [MAX_SEQ_LEN-1:0] SEQ_X = MAX_SEQ_LEN'(SEQ);
  localparam bit OVL = (OVERLAP != 0);

  logic [SW-1:0] nx0 [NS];
  logic [SW-1:0] nx1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_ns
    if (k <= SEQ_LEN) begin : g_v
      assign nx0[k] = SW'(seq_next(SEQ_X, SEQ_LEN, k, 1'b0, OVL));
      assign nx1[k] = SW'(seq_next(SEQ_X, SEQ_LEN, k, 1'b1, OVL));
    end else begin : g_u
      assign nx0[k] = '0;
      assign nx1[k] = '0;
    end
  end

  assign ps_nxt = din ? nx1[ps] : nx0[ps];

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector with valid and clear.
// Define MOORE_SEQ_MATCH_CNT_EN to build the saturating match counter.
module moore_seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] SEQ     = 3'b101,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = $clog2(SEQ_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  output logic             y,
  output logic [SW-1:0]    ps_out,
  output logic [CNT_W-1:0] match_cnt
);

  if (SEQ_LEN < 2 || SEQ_LEN > MAX_SEQ_LEN) begin : g_bad_len
    $error("SEQ_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $error("CNT_W must be in 1..32");
  end

  localparam logic [SW-1:0] S0    = '0;
  localparam logic [SW-1:0] S_DET = SW'(SEQ_LEN);

  logic [SW-1:0] ps;
  logic [SW-1:0] ps_nxt;

  seq_det_next_state #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ),
    .OVERLAP (OVERLAP)
  ) u_ns (
    .ps     (ps),
    .din    (din),
    .ps_nxt (ps_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ps <= S0;
    else if (clr)     ps <= S0;
    else if (din_vld) ps <= ps_nxt;
  end

  assign y      = (ps == S_DET);
  assign ps_out = ps;

`ifdef MOORE_SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (din_vld && ps_nxt == S_DET && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Scoreboard bench: four detector configurations on one shared stream,
// checked against a suffix-matching reference model.
module tb_moore_seq_detector_param;

  logic clk = 1'b0;
  logic rst, clr, din_vld, din;
  always #5 clk = ~clk;

  logic [1:0] ps0, ps1;
  logic [2:0] ps2, ps3;
  logic       y0, y1, y2, y3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  moore_seq_detector_param #(.SEQ_LEN(3), .SEQ(3'b101), .OVERLAP(1),
    .CNT_W(8)) d0 (.clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld),
    .din(din), .y(y0), .ps_out(ps0), .match_cnt(c0));
  moore_seq_detector_param #(.SEQ_LEN(3), .SEQ(3'b101), .OVERLAP(0),
    .CNT_W(8)) d1 (.clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld),
    .din(din), .y(y1), .ps_out(ps1), .match_cnt(c1));
  moore_seq_detector_param #(.SEQ_LEN(4), .SEQ(4'b1101), .OVERLAP(1),
    .CNT_W(8)) d2 (.clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld),
    .din(din), .y(y2), .ps_out(ps2), .match_cnt(c2));
  moore_seq_detector_param #(.SEQ_LEN(4), .SEQ(4'b1111), .OVERLAP(1),
    .CNT_W(2)) d3 (.clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld),
    .din(din), .y(y3), .ps_out(ps3), .match_cnt(c3));

  typedef struct packed {
    int   ps;
    logic y;
    int   cnt;
  } exp_t;

  exp_t sbq[4][$];
  int tests = 0;
  int fails = 0;

  int          plen[4] = '{3, 3, 4, 4};
  logic [15:0] pat[4]  = '{16'h5, 16'h5, 16'hD, 16'hF};
  bit          ovl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax[4] = '{255, 255, 255, 3};
  bit          hq[4][$];
  int          mst[4];
  int          mcnt[4];

  function automatic int expc(int n);
`ifdef MOORE_SEQ_MATCH_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic int act_ps(int i);
    case (i)
      0: return int'(ps0);
      1: return int'(ps1);
      2: return int'(ps2);
      default: return int'(ps3);
    endcase
  endfunction

  function automatic int act_y(int i);
    case (i)
      0: return int'(y0);
      1: return int'(y1);
      2: return int'(y2);
      default: return int'(y3);
    endcase
  endfunction

  function automatic int act_cnt(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  // Longest tail of the accepted history that is a pattern prefix.
  function automatic int mstate(int i);
    int n;
    bit ok;
    n = hq[i].size();
    for (int k = (n < plen[i]) ? n : plen[i]; k > 0; k--) begin
      ok = 1'b1;
      for (int t = 0; t < k; t++)
        if (hq[i][n-k+t] != pat[i][plen[i]-1-t]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hq[i].delete();
      mst[i]  = 0;
      mcnt[i] = 0;
    end
  endtask

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(bit v, bit d, bit c);
    exp_t e;
    @(negedge clk);
    din_vld = v;
    din     = d;
    clr     = c;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        hq[i].delete();
        mst[i]  = 0;
        mcnt[i] = 0;
      end else if (v) begin
        if (!ovl[i] && mst[i] == plen[i]) hq[i].delete();
        hq[i].push_back(d);
        if (hq[i].size() > 16) void'(hq[i].pop_front());
        mst[i] = mstate(i);
        if (mst[i] == plen[i] && mcnt[i] < cmax[i]) mcnt[i]++;
      end
      e.ps  = mst[i];
      e.y   = (mst[i] == plen[i]);
      e.cnt = expc(mcnt[i]);
      sbq[i].push_back(e);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(int n, logic [15:0] bits);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sbq[i].size() > 0) begin
          e = sbq[i].pop_front();
          check($sformatf("d%0d.ps", i), act_ps(i), e.ps);
          check($sformatf("d%0d.y", i), act_y(i), int'(e.y));
          check($sformatf("d%0d.cnt", i), act_cnt(i), e.cnt);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset.d%0d.ps", i), act_ps(i), 0);
      check($sformatf("reset.d%0d.y", i), act_y(i), 0);
      check($sformatf("reset.d%0d.cnt", i), act_cnt(i), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    feed(5, 16'b10101);
    settle();
    check("t1.ovl.ps", act_ps(0), 3);
    check("t1.ovl.y", act_y(0), 1);
    check("t1.ovl.cnt", act_cnt(0), expc(2));
    check("t2.novl.ps", act_ps(1), 1);
    check("t2.novl.y", act_y(1), 0);
    check("t2.novl.cnt", act_cnt(1), expc(1));

    step(1'b0, 1'b0, 1'b1);
    feed(5, 16'b11101);
    settle();
    check("t3.ps", act_ps(2), 4);
    check("t3.y", act_y(2), 1);

    step(1'b0, 1'b0, 1'b1);
    feed(2, 16'b10);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    settle();
    check("t4.gap.ps", act_ps(0), 2);
    check("t4.gap.y", act_y(0), 0);
    step(1'b1, 1'b1, 1'b0);
    settle();
    check("t4.done.y", act_y(0), 1);

    step(1'b0, 1'b0, 1'b1);
    feed(7, 16'b1111111);
    settle();
    check("t5.ps", act_ps(3), 4);
    check("t5.y", act_y(3), 1);
    check("t5.cnt", act_cnt(3), expc(3));

    step(1'b0, 1'b0, 1'b1);
    feed(2, 16'b10);
    settle();
    check("t6.pre.ps", act_ps(0), 2);
    rst = 1'b1;
    #1;
    check("t6.rst.ps", act_ps(0), 0);
    check("t6.rst.y", act_y(2), 0);
    check("t6.rst.cnt", act_cnt(0), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    feed(2, 16'b10);
    step(1'b1, 1'b1, 1'b1);
    settle();
    check("t6.clr.ps", act_ps(0), 0);
    check("t6.clr.y", act_y(0), 0);

    repeat (3000)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 79) == 0);
    settle();
    for (int i = 0; i < 4; i++)
      check($sformatf("drain.d%0d", i), sbq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector_param.md
Name: moore_seq_detector_param

Overview:
Parametrised Moore-style serial sequence detector, successor to the fixed 3-bit "101" Moore detector.
- Pattern length, pattern value and overlap mode are parameters.
- Adds an input-valid qualifier, a synchronous clear and an optional saturating match counter.
- Sits on a serial bit stream; `y` feeds downstream framing/alarm logic; `ps_out` is exported for debug and bench observation.

Parameters:
- SEQ_LEN, 3: pattern length in bits, 2..16.
- SEQ, 3'b101: pattern value, SEQ_LEN bits wide; MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, 8: match counter width, 1..32.
- SW, $clog2(SEQ_LEN+1): state width (localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear; returns FSM and counter to reset values.
- din_vld  in  1  qualifies din; FSM advances only when high.
- din  in  1  serial data bit.
- y  out  1  Moore detect output; high only in state SEQ_LEN.
- ps_out  out  SW  present state, 0..SEQ_LEN.
- match_cnt  out  CNT_W  saturating detection count; tied to 0 when the feature is compiled out.

Behaviour:
- **Reset** (rst high, async): ps_out=0, y=0, match_cnt=0. Outputs are held while rst is high.
- **States:** S0..S_SEQ_LEN. State k means the last k accepted bits equal the first k pattern bits. S_SEQ_LEN is DETECT.
- **Expected bit** in state k (k<SEQ_LEN): SEQ[SEQ_LEN-1-k].
- **Transitions** on a clock edge with din_vld=1 and clr=0:
  - k<SEQ_LEN, din equals expected bit: go to k+1.
  - k<SEQ_LEN, mismatch: go to the longest proper suffix of (prefix_k, din) that is also a pattern prefix, i.e. the KMP failure rule. This is computed at elaboration; no runtime tables.
  - DETECT, OVERLAP=1: step from state fail(SEQ_LEN) with din using the rule above.
  - DETECT, OVERLAP=0: step from S0 with din.
- **din_vld=0:** state, y and match_cnt all hold. DETECT persists and y stays high.
- **clr=1:** ps_out←0, y←0, match_cnt←0 at the next edge. clr has priority over din_vld.
- **Latency:** y is registered from state. It rises in the cycle after the edge that samples the final pattern bit, and stays high for exactly one accepted bit unless the next accepted bit completes the pattern again. Back-to-back completion is only possible when OVERLAP=1 and the pattern is self-overlapping, e.g. 1111.
- **y** is a pure decode of ps_out, with no combinational path from din.
- **Reset mid-operation:** asynchronous return to S0 regardless of din_vld or clr.
- **Elaboration checks:** SEQ_LEN outside 2..16 or CNT_W outside 1..32 is an elaboration error, via a generate-time $error.

Optional Feature:
Macro MOORE_SEQ_MATCH_CNT_EN.
- **Defined:** match_cnt increments by 1 on every edge where the next state is DETECT, with din_vld=1 and clr=0. It saturates at 2^CNT_W-1 and holds there. Cleared by rst or clr.
- **Undefined:** no counter register is built; match_cnt is constant 0. All FSM behaviour is unchanged.

Decomposition:
- **Shared package `seq_det_pkg`:**
  - function `seq_fail(seq, len, k)` returning the failure state.
  - function `seq_next(seq, len, k, bit, overlap)` returning the next state.
  - constant MAX_SEQ_LEN=16.
- **Sub-module `seq_det_next_state`:** combinational next-state logic, parametrised identically and built from the package functions.
- **Top module:** holds the state register, y decode and optional counter.

Test Plan:
1. Defaults (101, OVERLAP=1), valid bits 1,0,1,0,1 → ps_out 1,2,3,2,3; y high after bits 3 and 5; match_cnt=2.
2. OVERLAP=0, same stream 1,0,1,0,1 → ps_out 1,2,3,0,1; y high after bit 3 only; match_cnt=1.
3. SEQ_LEN=4, SEQ=4'b1101, stream 1,1,1,0,1 → ps_out 1,2,2,3,4; y high after bit 5; prefix mismatch recovers to state 2, not 0.
4. Defaults, bits 1,0 then din_vld=0 for 3 cycles with din=1, then valid 1 → ps_out holds at 2 during the gap; y asserts only after the valid 1.
5. SEQ=4'b1111, OVERLAP=1, CNT_W=2, seven valid 1s → y high after bits 4,5,6,7; match_cnt reaches 3 and saturates.
6. Mid-pattern (ps_out=2): assert rst asynchronously between edges → ps_out=0, y=0, match_cnt=0 immediately. Repeat using clr → same values at the next edge.
